// File: rtl/sequence_game_ctrl.sv
// Memory-game sequencer: freezes the LFSR to capture a code each round, plays the stored sequence
// on the LEDs, then checks user entries. Define INPUT_TIMEOUT_EN to make an idle WAIT_IN time out to LOSE.
module sequence_game_ctrl #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 25000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   random_value,
    output logic                         lfsr_stop,
    input  logic                         btn_valid,
    input  logic [2:0]                   btn_code,
    output logic [2:0]                   leds,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         busy,
    output logic                         win,
    output logic                         lose
);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int TM1  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE} state_t;

    state_t        state;
    logic [2:0]    mem [MAX_LEN];
    logic [LW-1:0] idx;
    logic [TW-1:0] timer;
    logic [2:0]    code;
    logic          last;

    // Only the three legal LFSR codes are stored; anything else becomes 001.
    always_comb begin
        code = 3'b001;
        if (random_value == 3'b001 || random_value == 3'b011 || random_value == 3'b111)
            code = random_value;
        last = (idx == level - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (state == APPEND)
            mem[level] <= code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            level     <= '0;
            idx       <= '0;
            timer     <= '0;
            leds      <= '0;
            lfsr_stop <= 1'b0;
            busy      <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else begin
            timer <= timer + 1'b1;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state     <= APPEND;
                        level     <= '0;
                        timer     <= '0;
                        lfsr_stop <= 1'b1;
                        busy      <= 1'b1;
                        win       <= 1'b0;
                        lose      <= 1'b0;
                    end
                end
                APPEND: begin
                    state     <= SHOW_ON;
                    level     <= level + 1'b1;
                    idx       <= '0;
                    timer     <= '0;
                    lfsr_stop <= 1'b0;
                    // In round one mem[0] is being written on this very edge.
                    leds      <= (level == '0) ? code : mem[0];
                end
                SHOW_ON: begin
                    if (timer == TW'(SHOW_CYCLES - 1)) begin
                        state <= SHOW_OFF;
                        timer <= '0;
                        leds  <= '0;
                    end
                end
                SHOW_OFF: begin
                    if (timer == TW'(GAP_CYCLES - 1)) begin
                        timer <= '0;
                        if (last) begin
                            state <= WAIT_IN;
                            idx   <= '0;
                        end else begin
                            state <= SHOW_ON;
                            idx   <= idx + 1'b1;
                            leds  <= mem[idx + 1'b1];
                        end
                    end
                end
                WAIT_IN: begin
                    if (btn_valid) begin
                        timer <= '0;
                        if (btn_code != mem[idx]) begin
                            state <= LOSE;
                            busy  <= 1'b0;
                            lose  <= 1'b1;
                        end else if (!last) begin
                            idx <= idx + 1'b1;
                        end else if (level == LW'(MAX_LEN)) begin
                            state <= WIN;
                            busy  <= 1'b0;
                            win   <= 1'b1;
                        end else begin
                            state     <= APPEND;
                            lfsr_stop <= 1'b1;
                        end
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= LOSE;
                        timer <= '0;
                        busy  <= 1'b0;
                        lose  <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_game_ctrl.sv
// Randomized bench for sequence_game_ctrl against a queue-based model of the played sequence.
module tb_sequence_game_ctrl;
    localparam int MAX_LEN        = 2;
    localparam int SHOW_CYCLES    = 4;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 10;
    localparam int LW             = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    random_value;
    logic          lfsr_stop;
    logic          btn_valid;
    logic [2:0]    btn_code;
    logic [2:0]    leds;
    logic [LW-1:0] level;
    logic          busy;
    logic          win;
    logic          lose;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] seq [$];

    always #5 clk = ~clk;

    sequence_game_ctrl #(
        .MAX_LEN(MAX_LEN),
        .SHOW_CYCLES(SHOW_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .random_value(random_value),
        .lfsr_stop(lfsr_stop),
        .btn_valid(btn_valid),
        .btn_code(btn_code),
        .leds(leds),
        .level(level),
        .busy(busy),
        .win(win),
        .lose(lose)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] stored_code(input logic [2:0] rv);
        return (rv == 3'b001 || rv == 3'b011 || rv == 3'b111) ? rv : 3'b001;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_terminal(input string tag, input logic w, input logic l);
        check({tag, "_leds"}, 32'(leds), 32'd0);
        check({tag, "_stop"}, 32'(lfsr_stop), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_win"}, 32'(win), 32'(w));
        check({tag, "_lose"}, 32'(lose), 32'(l));
    endtask

    task automatic start_game;
        start     = 1'b1;
        btn_valid = 1'($urandom);
        btn_code  = 3'($urandom);
        tick;
        start     = 1'b0;
        btn_valid = 1'b0;
        seq.delete();
        check("start_busy", 32'(busy), 32'd1);
        check("start_win", 32'(win), 32'd0);
        check("start_lose", 32'(lose), 32'd0);
    endtask

    // Expects to be called with the DUT in APPEND; returns with it in WAIT_IN.
    task automatic append_round(input logic [2:0] rv, input bit noise);
        check("append_stop", 32'(lfsr_stop), 32'd1);
        check("append_level", 32'(level), 32'(seq.size()));
        random_value = rv;
        tick;
        random_value = 3'($urandom);
        seq.push_back(stored_code(rv));
        check("round_level", 32'(level), 32'(seq.size()));
        foreach (seq[k]) begin
            for (int c = 0; c < SHOW_CYCLES + GAP_CYCLES; c++) begin
                check(c < SHOW_CYCLES ? "show_leds" : "gap_leds", 32'(leds),
                      c < SHOW_CYCLES ? 32'(seq[k]) : 32'd0);
                check("play_stop", 32'(lfsr_stop), 32'd0);
                check("play_busy", 32'(busy), 32'd1);
                check("play_lose", 32'(lose), 32'd0);
                if (noise) begin
                    btn_valid = 1'($urandom);
                    btn_code  = 3'($urandom);
                    start     = 1'($urandom);
                end
                tick;
                btn_valid = 1'b0;
                start     = 1'b0;
            end
        end
        check("wait_entry_leds", 32'(leds), 32'd0);
        check("wait_entry_busy", 32'(busy), 32'd1);
    endtask

    // outcome: 0 = next round (APPEND), 1 = win, 2 = lose
    task automatic enter_seq(input int wrong_pct, input int first_wait, output int outcome);
        int w;
        bit wrong;
        outcome = 0;
        for (int k = 0; k < seq.size(); k++) begin
            w = (k == 0 && first_wait >= 0) ? first_wait : int'($urandom_range(0, 3));
            repeat (w) begin
                check("wait_leds", 32'(leds), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
                check("wait_lose", 32'(lose), 32'd0);
                start = 1'($urandom);
                tick;
                start = 1'b0;
            end
            wrong     = ($urandom_range(0, 99) < wrong_pct);
            btn_code  = wrong ? (seq[k] ^ 3'($urandom_range(1, 7))) : seq[k];
            btn_valid = 1'b1;
            start     = 1'($urandom);
            tick;
            btn_valid = 1'b0;
            start     = 1'b0;
            if (wrong) begin
                check_terminal("lose", 1'b0, 1'b1);
                check("lose_level", 32'(level), 32'(seq.size()));
                btn_valid = 1'b1;
                btn_code  = seq[k];
                tick;
                btn_valid = 1'b0;
                check_terminal("lose_hold", 1'b0, 1'b1);
                outcome = 2;
                return;
            end
            if (k < seq.size() - 1) begin
                check("entry_busy", 32'(busy), 32'd1);
                check("entry_stop", 32'(lfsr_stop), 32'd0);
                check("entry_lose", 32'(lose), 32'd0);
            end
        end
        if (seq.size() == MAX_LEN) begin
            check_terminal("win", 1'b1, 1'b0);
            check("win_level", 32'(level), 32'(MAX_LEN));
            outcome = 1;
        end
    endtask

    task automatic play_game(input logic [2:0] rv_a, input logic [2:0] rv_b, input int wrong_pct);
        int outcome;
        start_game;
        append_round(rv_a, 1'b1);
        enter_seq(wrong_pct, -1, outcome);
        while (outcome == 0) begin
            append_round(rv_b, 1'b1);
            enter_seq(wrong_pct, -1, outcome);
        end
    endtask

    initial begin
        int outcome;
        reset        = 1'b1;
        start        = 1'b0;
        btn_valid    = 1'b0;
        btn_code     = '0;
        random_value = '0;
        repeat (3) tick;
        check_terminal("reset", 1'b0, 1'b0);
        check("reset_level", 32'(level), 32'd0);
        reset = 1'b0;
        tick;
        check_terminal("idle", 1'b0, 1'b0);

        btn_valid = 1'b1;
        btn_code  = 3'b001;
        tick;
        btn_valid = 1'b0;
        check_terminal("idle_btn", 1'b0, 1'b0);

        // asynchronous reset in the middle of SHOW_ON
        start_game;
        check("pre_reset_stop", 32'(lfsr_stop), 32'd1);
        random_value = 3'b011;
        tick;
        check("pre_reset_leds", 32'(leds), 32'd3);
        tick;
        #2 reset = 1'b1;
        #1;
        check_terminal("async_reset", 1'b0, 1'b0);
        check("async_reset_level", 32'(level), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        check_terminal("post_reset", 1'b0, 1'b0);

        play_game(3'b011, 3'b111, 0);
        start_game;
        append_round(3'b011, 1'b0);
        enter_seq(100, -1, outcome);
        play_game(3'b000, 3'b101, 0);

`ifdef INPUT_TIMEOUT_EN
        start_game;
        append_round(3'b001, 1'b0);
        repeat (TIMEOUT_CYCLES - 1) begin
            check("pre_timeout_lose", 32'(lose), 32'd0);
            tick;
        end
        check("pre_timeout_busy", 32'(busy), 32'd1);
        tick;
        check_terminal("timeout", 1'b0, 1'b1);

        start_game;
        append_round(3'b011, 1'b0);
        enter_seq(0, TIMEOUT_CYCLES - 1, outcome);
        append_round(3'b111, 1'b0);
        enter_seq(0, -1, outcome);
`else
        start_game;
        append_round(3'b011, 1'b0);
        enter_seq(0, 1000, outcome);
        append_round(3'b111, 1'b0);
        enter_seq(0, -1, outcome);
`endif

        repeat (20) play_game(3'($urandom), 3'($urandom), 25);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/sequence_game_ctrl.md
Name: sequence_game_ctrl

Overview:
Game sequencer that consumes the 3-bit random LED code from the LFSR generator and drives that generator's stop input. Each round it freezes the LFSR for one cycle, appends the sampled code to a sequence buffer, and plays the whole sequence on the LEDs. It then checks user button entries against the stored sequence. It sits between the LFSR generator, the debounced button front end and the LED outputs of the memory-game design.

Parameters:
MAX_LEN, 16, sequence length that wins the game (legal range 1..32)
SHOW_CYCLES, 25000000, clocks each code is displayed on leds
GAP_CYCLES, 12500000, clocks leds are dark between displayed codes
TIMEOUT_CYCLES, 250000000, input timeout (used only with INPUT_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a new game
random_value  input  3  code from the LFSR generator (001/011/111)
lfsr_stop  output  1  high = LFSR holds its state; connects to the generator's stop input
btn_valid  input  1  single-cycle pulse; a user entry is present on btn_code
btn_code  input  3  user-entered code
leds  output  3  displayed code
level  output  $clog2(MAX_LEN+1)  current sequence length
busy  output  1  high in every state except IDLE, WIN and LOSE
win  output  1  high in the WIN state
lose  output  1  high in the LOSE state

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset applies at any time, including mid-playback or mid-input.
  - Result: state=IDLE, level=0, index=0, timers=0.
  - Outputs: leds=000, lfsr_stop=0, busy=0, win=0, lose=0.
  - Buffer contents are don't-care after reset.
- Sequence buffer: MAX_LEN x 3-bit registers. Write pointer is level; read pointer is idx.
- All outputs are registered or decoded from the state register. lfsr_stop=1 only in APPEND.
- IDLE: leds=000, LFSR free-runs. On start: level<=0, then go to APPEND.
- APPEND (exactly 1 cycle):
  - lfsr_stop=1; random_value is sampled on this cycle's edge.
  - If the sample is 000 or any code other than 001/011/111, store 001 instead.
  - mem[level]<=code; level<=level+1; idx<=0; go to SHOW_ON.
- SHOW_ON: leds=mem[idx] for exactly SHOW_CYCLES clocks, then go to SHOW_OFF.
- SHOW_OFF: leds=000 for exactly GAP_CYCLES clocks.
  - If idx==level-1: idx<=0, go to WAIT_IN.
  - Otherwise: idx<=idx+1, go to SHOW_ON.
- WAIT_IN: leds=000.
  - On btn_valid with btn_code==mem[idx]:
    - If idx==level-1 and level==MAX_LEN: go to WIN.
    - If idx==level-1 and level<MAX_LEN: go to APPEND.
    - Otherwise: idx<=idx+1.
  - On btn_valid with btn_code!=mem[idx]: go to LOSE.
- WIN / LOSE: terminal states; win or lose held high, leds=000. On start: level<=0, go to APPEND.
- btn_valid is ignored outside WAIT_IN, including during playback.
- start is ignored while busy=1.
- start and btn_valid in the same cycle in WAIT_IN: btn_valid is processed and start is ignored.
- Timers are cleared on every state entry. A 1-cycle APPEND guarantees the LFSR advances between rounds.

Optional Feature:
- Macro: INPUT_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_IN and is cleared on entry and on each accepted correct btn_valid.
  - When the counter reaches TIMEOUT_CYCLES with no btn_valid, go to LOSE.
  - A btn_valid on the expiry cycle takes priority over the timeout.
- When undefined: WAIT_IN waits indefinitely; the counter logic and TIMEOUT_CYCLES have no effect.

Test Plan:
(Bench parameters: MAX_LEN=2, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=10.)
- Reset, hold, then release; pulse reset during SHOW_ON -> leds=000, level=0, busy=0, win=0, lose=0, lfsr_stop=0 immediately on assertion.
- start with random_value=011 -> lfsr_stop high for exactly 1 cycle; level=1; leds=011 for 4 cycles, then 000 for 2 cycles; then WAIT_IN with busy=1.
- In WAIT_IN, btn_code=011 -> APPEND with random_value=111; level=2; playback 011(4),000(2),111(4),000(2). Then enter 011 and 111 -> win=1, busy=0, level=2.
- Enter a wrong code (001 when 011 is expected) -> lose=1 next cycle. A later btn_valid leaves lose=1. start -> lose=0, level=1, new playback.
- random_value=000 during APPEND -> stored code plays back as 001. btn_valid pulses during SHOW_ON are ignored (idx unchanged, no LOSE).
- With INPUT_TIMEOUT_EN and no input for 10 cycles in WAIT_IN -> lose=1. btn_valid on the 10th cycle -> accepted, no timeout. Without the macro, 1000 idle cycles -> still WAIT_IN.
